// File: rtl/mult8_sched.sv
// Round-robin front end that shares one iterative 8x8 multiplier among NUM_REQ clients.
// One multiply is in flight at a time; results return tagged with the requester index.
module mult8_sched #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                       i_clk,
  input  logic                       i_arst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*8-1:0]       i_req_a,
  input  logic [NUM_REQ*8-1:0]       i_req_b,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [7:0]                 o_mult_a,
  output logic [7:0]                 o_mult_b,
  output logic                       o_mult_start,
  input  logic [15:0]                i_mult_product,
  input  logic                       i_mult_done,
  output logic                       o_rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] o_rsp_id,
  output logic [15:0]                o_rsp_product,
  output logic                       o_rsp_err,
  input  logic                       i_rsp_ready,
  output logic                       o_busy
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e state_q, state_d;

  logic [ID_W-1:0]    rr_q, rr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [7:0]         a_q, a_d;
  logic [7:0]         b_q, b_d;
  logic [15:0]        prod_q, prod_d;
  logic               err_q, err_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic [ID_W-1:0]    arb_idx;
  logic [ID_W-1:0]    win_id;
  logic               win_vld;
  logic [NUM_REQ-1:0] grant;
  logic [7:0]         sel_a;
  logic [7:0]         sel_b;
  logic               idle_en;
  logic               hs;
  logic               tmo_hit;

  // Scan from the rr pointer upward with wrap; first valid requester wins.
  always_comb begin
    arb_idx = rr_q;
    win_id  = '0;
    win_vld = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_vld && i_req_valid[arb_idx]) begin
        win_vld = 1'b1;
        win_id  = arb_idx;
      end
      arb_idx = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
    end
  end

  always_comb begin
    grant = '0;
    if (win_vld) begin
      grant[win_id] = 1'b1;
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (win_id == ID_W'(k)) begin
        sel_a = i_req_a[8*k +: 8];
        sel_b = i_req_b[8*k +: 8];
      end
    end
  end

  // Ready is gated by reset so every output reads 0 while i_arst is high.
  assign idle_en     = (state_q == StIdle) && !i_arst;
  assign o_req_ready = idle_en ? grant : '0;
  assign hs          = idle_en && win_vld;
  assign tmo_hit     = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hs) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (i_mult_done || tmo_hit) state_d = StResp;
      StResp:  if (i_rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_mult_start = 1'b0;
    o_rsp_valid  = 1'b0;
    o_busy       = 1'b1;
    unique case (state_q)
      StIdle:  o_busy = 1'b0;
      StIssue: o_mult_start = 1'b1;
      StWait:  ;
      StResp:  o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rr_d   = rr_q;
    id_d   = id_q;
    a_d    = a_q;
    b_d    = b_q;
    prod_d = prod_q;
    err_d  = err_q;
    tmo_d  = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          id_d = win_id;
          a_d  = sel_a;
          b_d  = sel_b;
          rr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
        end
      end
      StIssue: tmo_d = '0;
      StWait: begin
        // A real done wins over a timeout landing on the same cycle.
        if (i_mult_done) begin
          prod_d = i_mult_product;
          err_d  = 1'b0;
        end else if (tmo_hit) begin
          prod_d = '0;
          err_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StResp:  ;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      rr_q   <= '0;
      id_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      err_q  <= 1'b0;
      tmo_q  <= '0;
    end else begin
      rr_q   <= rr_d;
      id_q   <= id_d;
      a_q    <= a_d;
      b_q    <= b_d;
      prod_q <= prod_d;
      err_q  <= err_d;
      tmo_q  <= tmo_d;
    end
  end

  assign o_mult_a      = a_q;
  assign o_mult_b      = b_q;
  assign o_rsp_id      = id_q;
  assign o_rsp_product = prod_q;
  assign o_rsp_err     = err_q;

endmodule

// File: tb/tb_mult8_sched.sv
// Bench for mult8_sched: a transaction-level model predicts every output each cycle, and a
// behavioural mult8 stub answers start pulses; directed scenarios add literal expectations.
module tb_mult8_sched;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic            i_clk = 1'b0;
  logic            i_arst;
  logic [N-1:0]    i_req_valid;
  logic [N*8-1:0]  i_req_a;
  logic [N*8-1:0]  i_req_b;
  logic [N-1:0]    o_req_ready;
  logic [7:0]      o_mult_a;
  logic [7:0]      o_mult_b;
  logic            o_mult_start;
  logic [15:0]     i_mult_product;
  logic            i_mult_done;
  logic            o_rsp_valid;
  logic [1:0]      o_rsp_id;
  logic [15:0]     o_rsp_product;
  logic            o_rsp_err;
  logic            i_rsp_ready;
  logic            o_busy;

  mult8_sched #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk         (i_clk),
    .i_arst        (i_arst),
    .i_req_valid   (i_req_valid),
    .i_req_a       (i_req_a),
    .i_req_b       (i_req_b),
    .o_req_ready   (o_req_ready),
    .o_mult_a      (o_mult_a),
    .o_mult_b      (o_mult_b),
    .o_mult_start  (o_mult_start),
    .i_mult_product(i_mult_product),
    .i_mult_done   (i_mult_done),
    .o_rsp_valid   (o_rsp_valid),
    .o_rsp_id      (o_rsp_id),
    .o_rsp_product (o_rsp_product),
    .o_rsp_err     (o_rsp_err),
    .i_rsp_ready   (i_rsp_ready),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: idle/busy, cycles since handshake, and the pending transaction.
  bit m_busy;
  int m_rr, m_t, m_id, m_a, m_b, m_rsp_at;
  bit m_err;

  // mult8 stub state.
  bit stub_dead;
  bit start_seen;
  int cnt, sa, sb, smp_a, smp_b;

  int granted;
  int rv_cnt;
  int hs_id_q[$], hs_cyc_q[$], st_cyc_q[$];
  int rsp_id_q[$], rsp_prod_q[$], rsp_err_q[$], rsp_cyc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk_q(input string name, input int q[$], input int i, input int exp);
    if (i < q.size()) begin
      chk(name, q[i], exp);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s actual=missing required=%0d", name, exp);
    end
  endtask

  task automatic chk_lat(input string name, input int a_q[$], input int b_q[$], input int exp);
    if (a_q.size() > 0 && b_q.size() > 0) begin
      chk(name, b_q[0] - a_q[0], exp);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s actual=missing required=%0d", name, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int i = 0; i < N; i++) begin
      if (v[(rr + i) % N]) return (rr + i) % N;
    end
    return -1;
  endfunction

  task automatic compare();
    int w;
    if (i_arst) begin
      chk("rst_ready", o_req_ready, 0);
      chk("rst_start", o_mult_start, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_rsp_valid", o_rsp_valid, 0);
      chk("rst_mult_a", o_mult_a, 0);
      chk("rst_mult_b", o_mult_b, 0);
      chk("rst_rsp_id", o_rsp_id, 0);
      chk("rst_rsp_product", o_rsp_product, 0);
      chk("rst_rsp_err", o_rsp_err, 0);
    end else if (!m_busy) begin
      w = pick(i_req_valid, m_rr);
      chk("req_ready", o_req_ready, (w < 0) ? 0 : (32'd1 << w));
      chk("idle_start", o_mult_start, 0);
      chk("idle_busy", o_busy, 0);
      chk("idle_rsp_valid", o_rsp_valid, 0);
    end else begin
      chk("busy_ready", o_req_ready, 0);
      chk("busy_busy", o_busy, 1);
      chk("start", o_mult_start, (m_t == 1) ? 1 : 0);
      chk("rsp_valid", o_rsp_valid, (m_t >= m_rsp_at) ? 1 : 0);
      if (m_t == 1) begin
        chk("mult_a", o_mult_a, m_a);
        chk("mult_b", o_mult_b, m_b);
      end
      if (m_t >= m_rsp_at) begin
        chk("rsp_id", o_rsp_id, m_id);
        chk("rsp_product", o_rsp_product, m_err ? 0 : m_a * m_b);
        chk("rsp_err", o_rsp_err, m_err);
      end
    end
  endtask

  task automatic log_events();
    granted = -1;
    start_seen = 1'b0;
    if (!i_arst) begin
      for (int k = 0; k < N; k++) begin
        if (o_req_ready[k] && i_req_valid[k]) begin
          granted = k;
          hs_id_q.push_back(k);
          hs_cyc_q.push_back(cyc);
        end
      end
      if (o_rsp_valid) rv_cnt++;
      if (o_rsp_valid && i_rsp_ready) begin
        rsp_id_q.push_back(int'(o_rsp_id));
        rsp_prod_q.push_back(int'(o_rsp_product));
        rsp_err_q.push_back(int'(o_rsp_err));
        rsp_cyc_q.push_back(cyc);
      end
      if (o_mult_start) begin
        st_cyc_q.push_back(cyc);
        start_seen = 1'b1;
        smp_a = int'(o_mult_a);
        smp_b = int'(o_mult_b);
      end
    end
  endtask

  task automatic model_update();
    int w;
    if (i_arst) begin
      m_busy = 1'b0;
      m_rr   = 0;
    end else if (!m_busy) begin
      w = pick(i_req_valid, m_rr);
      if (w >= 0) begin
        m_busy   = 1'b1;
        m_t      = 1;
        m_id     = w;
        m_a      = int'(i_req_a[8*w +: 8]);
        m_b      = int'(i_req_b[8*w +: 8]);
        m_err    = stub_dead;
        m_rsp_at = stub_dead ? 2 + TMO : 11;
        m_rr     = (w + 1) % N;
      end
    end else if (m_t >= m_rsp_at && i_rsp_ready) begin
      m_busy = 1'b0;
    end else begin
      m_t++;
    end
  endtask

  // Done arrives 9 cycles after the start cycle; product carries junk when done is low.
  task automatic stub_update();
    bit done_now;
    done_now = 1'b0;
    if (start_seen) begin
      cnt = 9;
      sa  = smp_a;
      sb  = smp_b;
    end
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) done_now = 1'b1;
    end
    i_mult_done    = done_now && !stub_dead;
    i_mult_product = (done_now && !stub_dead) ? 16'(sa * sb) : 16'($urandom);
  endtask

  task automatic step();
    @(negedge i_clk);
    compare();
    log_events();
    @(posedge i_clk);
    model_update();
    #1;
    stub_update();
    if (granted >= 0) i_req_valid[granted] = 1'b0;
    cyc++;
  endtask

  task automatic clr_logs();
    hs_id_q.delete();
    hs_cyc_q.delete();
    st_cyc_q.delete();
    rsp_id_q.delete();
    rsp_prod_q.delete();
    rsp_err_q.delete();
    rsp_cyc_q.delete();
    rv_cnt = 0;
  endtask

  task automatic raise(input int k, input int a, input int b);
    i_req_valid[k]    = 1'b1;
    i_req_a[8*k +: 8] = 8'(a);
    i_req_b[8*k +: 8] = 8'(b);
  endtask

  function automatic int rnd_op();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 0;
    if (r == 1) return 255;
    return $urandom_range(0, 255);
  endfunction

  initial begin
    i_arst = 1'b1;
    i_req_valid = '1;
    i_req_a = {8'd40, 8'd30, 8'd20, 8'd10};
    i_req_b = {8'd4, 8'd3, 8'd2, 8'd1};
    i_rsp_ready = 1'b1;
    i_mult_done = 1'b0;
    i_mult_product = '0;
    stub_dead = 1'b0;
    cnt = 0;
    m_busy = 1'b0;
    m_rr = 0;
    clr_logs();
    repeat (2) step();
    i_arst = 1'b0;

    // All four valid out of reset: grants 0,1,2,3, each 12 cycles apart.
    repeat (50) step();
    for (int i = 0; i < 4; i++) chk_q("t2_order", hs_id_q, i, i);
    for (int i = 1; i < 4; i++) begin
      if (hs_cyc_q.size() > i) chk("t2_spacing", hs_cyc_q[i] - hs_cyc_q[i-1], 12);
    end
    chk_q("t2_prod3", rsp_prod_q, 3, 160);
    clr_logs();
    raise(0, 5, 6);
    raise(2, 7, 8);
    repeat (26) step();
    chk_q("t2_wrap_first", hs_id_q, 0, 0);
    chk_q("t2_wrap_second", hs_id_q, 1, 2);

    // Single request with fixed latency.
    clr_logs();
    raise(1, 13, 11);
    repeat (14) step();
    chk_q("t1_hs_id", hs_id_q, 0, 1);
    chk_q("t1_rsp_id", rsp_id_q, 0, 1);
    chk_q("t1_product", rsp_prod_q, 0, 143);
    chk_q("t1_err", rsp_err_q, 0, 0);
    chk_lat("t1_start_lat", hs_cyc_q, st_cyc_q, 1);
    chk_lat("t1_rsp_lat", hs_cyc_q, rsp_cyc_q, 11);

    // Backpressure: response held for 5 cycles before accept.
    clr_logs();
    raise(2, 200, 3);
    i_rsp_ready = 1'b0;
    repeat (16) step();
    i_rsp_ready = 1'b1;
    repeat (3) step();
    chk_q("t3_product", rsp_prod_q, 0, 600);
    chk_q("t3_id", rsp_id_q, 0, 2);
    chk_lat("t3_accept_lat", hs_cyc_q, rsp_cyc_q, 16);
    chk("t3_valid_cycles", rv_cnt, 6);

    // Operand corners, then spurious done pulses while idle.
    clr_logs();
    raise(0, 255, 255);
    repeat (13) step();
    raise(3, 0, 77);
    repeat (13) step();
    raise(1, 1, 255);
    repeat (13) step();
    chk_q("t4_max", rsp_prod_q, 0, 65025);
    chk_q("t4_zero", rsp_prod_q, 1, 0);
    chk_q("t4_one", rsp_prod_q, 2, 255);
    chk_q("t4_id_zero", rsp_id_q, 1, 3);
    repeat (4) begin
      i_mult_done = 1'b1;
      i_mult_product = 16'h1234;
      step();
    end
    repeat (3) step();
    chk("t4_spur_no_rsp", rsp_id_q.size(), 3);

    // Asynchronous reset four cycles into WAIT discards the in-flight multiply.
    clr_logs();
    raise(3, 50, 5);
    repeat (4) step();
    raise(0, 7, 9);
    repeat (2) step();
    #2;
    i_arst = 1'b1;
    #1;
    compare();
    repeat (2) step();
    i_arst = 1'b0;
    repeat (14) step();
    chk("t5_rsp_count", rsp_id_q.size(), 1);
    chk_q("t5_hs_after", hs_id_q, 1, 0);
    chk_q("t5_rsp_id", rsp_id_q, 0, 0);
    chk_q("t5_product", rsp_prod_q, 0, 63);
    chk_q("t5_err", rsp_err_q, 0, 0);
    if (hs_cyc_q.size() > 1 && rsp_cyc_q.size() > 0) begin
      chk("t5_lat", rsp_cyc_q[0] - hs_cyc_q[1], 11);
    end

    // Dead multiplier: timeout after 16 WAIT cycles.
    clr_logs();
    stub_dead = 1'b1;
    raise(2, 3, 4);
    repeat (22) step();
    stub_dead = 1'b0;
    chk_q("t6_id", rsp_id_q, 0, 2);
    chk_q("t6_product", rsp_prod_q, 0, 0);
    chk_q("t6_err", rsp_err_q, 0, 1);
    chk_lat("t6_lat", hs_cyc_q, rsp_cyc_q, 18);

    // Randomized traffic, backpressure, spurious done and occasional dead multiplier.
    repeat (3000) begin
      for (int k = 0; k < N; k++) begin
        if (!i_req_valid[k] && $urandom_range(0, 3) == 0) raise(k, rnd_op(), rnd_op());
      end
      i_rsp_ready = ($urandom_range(0, 3) != 0);
      if (!m_busy && $urandom_range(0, 39) == 0) stub_dead = !stub_dead;
      if ($urandom_range(0, 7) == 0 && (!m_busy || m_t <= 1 || m_t >= m_rsp_at)) begin
        i_mult_done = 1'b1;
      end
      step();
    end
    stub_dead = 1'b0;
    i_req_valid = '0;
    i_rsp_ready = 1'b1;
    repeat (25) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
